// File: rtl/compare_iter_s_pkg.sv
// Shared types and helpers for the iterative magnitude comparator.
// The sign bias maps two's-complement order onto plain unsigned order.
package compare_pkg;

    typedef enum logic [1:0] {
        CMP_IDLE = 2'd0,
        CMP_RUN  = 2'd1,
        CMP_DONE = 2'd2
    } cmp_state_e;

    typedef struct packed {
        logic eq;
        logic agt;
        logic blt;
    } cmp_res_t;

    // Widest operand the bias helper handles; callers size-cast in and out.
    localparam int BIAS_MAX_W = 256;

    // Inverts bit w-1 of x when en is set.
    function automatic logic [BIAS_MAX_W-1:0] bias_sign(
        input logic [BIAS_MAX_W-1:0] x,
        input logic                  en,
        input int unsigned           w
    );
        logic [BIAS_MAX_W-1:0] mask;
        mask = (en && (w > 0)) ? (BIAS_MAX_W'(1) << (w - 1)) : '0;
        return x ^ mask;
    endfunction

endpackage

// File: rtl/compare_iter_s_chunk.sv
// Combinational unsigned compare of one CHUNK-wide slice.
module compare_chunk_u #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             equal_o,
    output logic             alarger_o,
    output logic             blarger_o
);

    assign equal_o   = (a_i == b_i);
    assign alarger_o = (a_i >  b_i);
    assign blarger_o = (a_i <  b_i);

endmodule

// File: rtl/compare_iter_s.sv
// Multi-cycle signed/unsigned magnitude comparator: scans MSB-first one chunk
// per cycle and stops at the first differing chunk.
module compare_iter_s
    import compare_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             equal_o,
    output logic             alarger_o,
    output logic             blarger_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int SLOTS  = 1 << IDXW;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("compare_iter_s: WIDTH must be a multiple of CHUNK");
    end
    if (WIDTH > BIAS_MAX_W) begin : g_bad_width
        $error("compare_iter_s: WIDTH exceeds BIAS_MAX_W");
    end

    cmp_state_e        state_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [IDXW-1:0]   idx_reg;
    cmp_res_t          res_reg;

    logic [WIDTH-1:0]  a_biased;
    logic [WIDTH-1:0]  b_biased;

    assign a_biased = WIDTH'(bias_sign(BIAS_MAX_W'(a_i), signed_i, WIDTH));
    assign b_biased = WIDTH'(bias_sign(BIAS_MAX_W'(b_i), signed_i, WIDTH));

    // Slice tables padded to a power of two so the index never runs off the end.
    logic [CHUNK-1:0] a_chunks [SLOTS];
    logic [CHUNK-1:0] b_chunks [SLOTS];

    genvar gi;
    for (gi = 0; gi < SLOTS; gi++) begin : g_slice
        if (gi < NCHUNK) begin : g_real
            assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
        end else begin : g_pad
            assign a_chunks[gi] = '0;
            assign b_chunks[gi] = '0;
        end
    end

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic             chunk_eq;
    logic             chunk_agt;
    logic             chunk_blt;

    assign a_slice = a_chunks[idx_reg];
    assign b_slice = b_chunks[idx_reg];

    compare_chunk_u #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i       (a_slice),
        .b_i       (b_slice),
        .equal_o   (chunk_eq),
        .alarger_o (chunk_agt),
        .blarger_o (chunk_blt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= CMP_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            res_reg   <= '0;
        end else begin
            case (state_reg)
                CMP_IDLE: begin
                    if (valid_i) begin
                        a_reg     <= a_biased;
                        b_reg     <= b_biased;
                        idx_reg   <= LAST_IDX;
                        res_reg   <= '0;
                        state_reg <= CMP_RUN;
                    end
                end
                CMP_RUN: begin
                    if (chunk_agt) begin
                        res_reg.agt <= 1'b1;
                        state_reg   <= CMP_DONE;
                    end else if (chunk_blt) begin
                        res_reg.blt <= 1'b1;
                        state_reg   <= CMP_DONE;
                    end else if (idx_reg == '0) begin
                        res_reg.eq  <= 1'b1;
                        state_reg   <= CMP_DONE;
                    end else begin
                        idx_reg     <= idx_reg - 1'b1;
                    end
                end
                CMP_DONE: begin
                    if (ready_i) begin
                        state_reg <= CMP_IDLE;
                    end
                end
                default: begin
                    state_reg <= CMP_IDLE;
                end
            endcase
        end
    end

    assign ready_o   = (state_reg == CMP_IDLE);
    assign valid_o   = (state_reg == CMP_DONE);
    assign equal_o   = res_reg.eq;
    assign alarger_o = res_reg.agt;
    assign blarger_o = res_reg.blt;

endmodule

// File: tb/tb_compare_iter_s.sv
// Directed and randomised bench for compare_iter_s (WIDTH=32, CHUNK=8).
module tb_compare_iter_s;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        signed_i;
    logic        valid_o;
    logic        ready_i;
    logic        equal_o;
    logic        alarger_o;
    logic        blarger_o;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    compare_iter_s #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .a_i       (a_i),
        .b_i       (b_i),
        .signed_i  (signed_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .equal_o   (equal_o),
        .alarger_o (alarger_o),
        .blarger_o (blarger_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned relational operators.
    function automatic logic [2:0] ref_res(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (a == b) return R_EQ;
        if (s) return ($signed(a) > $signed(b)) ? R_GT : R_LT;
        return (a > b) ? R_GT : R_LT;
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = a ^ b;
        for (int k = 3; k >= 0; k--) begin
            if (d[k*8 +: 8] != 8'h00) return 4 - k;
        end
        return 4;
    endfunction

    // Invariants sampled mid-cycle: one-hot while valid, all clear during RUN.
    always @(negedge clk_i) begin
        if (mon_en && !rst_i) begin
            if (valid_o)
                check("onehot", 32'($countones({equal_o, alarger_o, blarger_o})), 32'd1);
            else if (!ready_o)
                check("run_clear", {29'd0, equal_o, alarger_o, blarger_o}, 32'd0);
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [2:0] exp_res, input int exp_lat,
                         input int stall, input bit toggle, input string tag);
        int n;
        int lat;
        n = 0;
        while (!ready_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
        a_i = a; b_i = b; signed_i = s; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i  = 1'b0;
        signed_i = ~s;
        a_i      = $urandom;
        lat      = 0;
        while (!valid_o && lat < 10) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, {29'd0, equal_o, alarger_o, blarger_o}, {29'd0, exp_res});
        for (int i = 0; i < stall; i++) begin
            ready_i = 1'b0;
            if (toggle) begin
                valid_i  = 1'b1;
                a_i      = $urandom;
                b_i      = $urandom;
                signed_i = ~signed_i;
            end
            @(posedge clk_i); #1;
            check({tag, "_hold_valid"}, {31'd0, valid_o}, 32'd1);
            check({tag, "_hold_ready"}, {31'd0, ready_o}, 32'd0);
            check({tag, "_hold_res"}, {29'd0, equal_o, alarger_o, blarger_o}, {29'd0, exp_res});
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        check({tag, "_post_valid"}, {31'd0, valid_o}, 32'd0);
        check({tag, "_post_ready"}, {31'd0, ready_o}, 32'd1);
        $display("txn %s a=%08h b=%08h s=%0d res=%03b lat=%0d", tag, a, b, s, exp_res, lat);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          n;

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        a_i = '0; b_i = '0; signed_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_res", {29'd0, equal_o, alarger_o, blarger_o}, 32'd0);
        mon_en = 1'b1;

        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, R_LT, 1, 0, 1'b0, "neg1_vs_1_s");
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, R_GT, 1, 0, 1'b0, "ones_vs_1_u");
        issue(32'h1234_5678, 32'h1234_5678, 1'b0, R_EQ, 4, 0, 1'b0, "eq_u");
        issue(32'h1234_5678, 32'h1234_5678, 1'b1, R_EQ, 4, 0, 1'b0, "eq_s");
        issue(32'h1234_5679, 32'h1234_5678, 1'b0, R_GT, 4, 0, 1'b0, "lsb_u");
        issue(32'h1234_0000, 32'h1235_0000, 1'b0, R_LT, 2, 0, 1'b0, "mid_u");
        issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, R_LT, 1, 0, 1'b0, "min_max_s");
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, R_LT, 1, 0, 1'b0, "neg1_vs_0_s");
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, R_GT, 1, 0, 1'b0, "ones_vs_0_u");
        issue(32'h0000_00FF, 32'h0000_0080, 1'b1, R_GT, 4, 0, 1'b0, "lsb_s");
        issue(32'hAB00_0000, 32'hAB00_0001, 1'b0, R_LT, 4, 5, 1'b1, "backpressure");

        // Reset during the second RUN cycle drops the transaction.
        a_i = '0; b_i = '0; signed_i = 1'b0; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("midrst_ready", {31'd0, ready_o}, 32'd1);
        check("midrst_valid", {31'd0, valid_o}, 32'd0);
        check("midrst_res", {29'd0, equal_o, alarger_o, blarger_o}, 32'd0);
        n = 0;
        repeat (6) begin
            @(posedge clk_i); #1;
            if (valid_o) n++;
        end
        check("midrst_no_output", 32'(n), 32'd0);
        $display("txn midrst a=00000000 b=00000000 dropped");

        for (int t = 0; t < 1000; t++) begin
            ra = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                rb = $urandom;
            end else begin
                rb = ra;
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(0, 3) == 0) rb[k*8 +: 8] = 8'($urandom);
            end
            rs = 1'($urandom_range(0, 1));
            issue(ra, rb, rs, ref_res(ra, rb, rs), ref_lat(ra, rb),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/compare_iter_s.md
Name: compare_iter_s

Overview:
Multi-cycle, parametrised magnitude comparator for WIDTH-bit operands. Supports both signed and unsigned comparison, selected per transaction. It scans the operands MSB-first, CHUNK bits per cycle, and terminates early at the first differing chunk. It sits beside the ALU/branch unit for wide-operand compares, where a single-cycle WIDTH-bit comparator would break timing. It uses a valid/ready handshake on both the input and output sides.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits compared per cycle; 1 <= CHUNK <= WIDTH.
(derived) NCHUNK = WIDTH/CHUNK; IDXW = max(1, $clog2(NCHUNK)).

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  reset; synchronous, active-high.
valid_i  input  1  operands and mode valid.
ready_o  output  1  block can accept a new transaction.
a_i  input  WIDTH  operand A.
b_i  input  WIDTH  operand B.
signed_i  input  1  1 = two's-complement compare, 0 = unsigned.
valid_o  output  1  result valid.
ready_i  input  1  consumer accepts result.
equal_o  output  1  A == B.
alarger_o  output  1  A > B.
blarger_o  output  1  A < B.

Behaviour:
- Reset (rst_i high at a rising edge):
  - state = IDLE.
  - valid_o = 0; equal_o, alarger_o and blarger_o all 0.
  - Operand registers and chunk index = 0.
  - Reset overrides everything, including mid-RUN and DONE; any in-flight transaction is dropped with no output.
- States: IDLE, RUN, DONE (encoding from the package).
- ready_o = (state == IDLE). valid_o = (state == DONE). Both are decoded from registered state.
- IDLE: on valid_i && ready_o, register the operands and go to RUN.
  - a_r = a_i, b_r = b_i, each with bit WIDTH-1 inverted when signed_i = 1. This bias maps signed order onto unsigned order.
  - idx = NCHUNK-1.
  - Clear all three result bits.
- RUN: each cycle, compare a_r[idx*CHUNK +: CHUNK] against b_r at the same slice, unsigned.
  - Chunk A > chunk B: alarger = 1, go to DONE.
  - Chunk A < chunk B: blarger = 1, go to DONE.
  - Chunks equal and idx == 0: equal = 1, go to DONE.
  - Chunks equal and idx > 0: idx = idx-1, stay in RUN.
  - valid_i is ignored in RUN.
- DONE: result registers and valid_o hold stable until ready_i = 1 is sampled, then go to IDLE.
  - No new accept is possible in the same cycle as the result handshake; ready_o rises the cycle after.
- Latency: if the accept happens at edge E and j chunks are examined (1 <= j <= NCHUNK), valid_o is high from edge E+j.
  - Best case 1 cycle, worst case NCHUNK cycles (equal operands or a difference only in the LSB chunk).
- Throughput: at most one transaction per j+2 cycles.
- Invariants:
  - Exactly one of equal_o, alarger_o, blarger_o is high whenever valid_o = 1.
  - All three are 0 from accept until the decision.
  - Result outputs come directly from flops (no combinational path from inputs).
- Boundary cases:
  - NCHUNK == 1 is a one-cycle compare with IDXW = 1.
  - In signed mode, MIN_INT vs MAX_INT gives blarger; -1 vs 0 gives blarger.
  - In unsigned mode, all-ones vs 0 gives alarger.
  - signed_i is sampled only at accept; later changes have no effect.
- Parameter check: an elaboration-time assertion fails if WIDTH % CHUNK != 0.

Decomposition:
- Package compare_pkg holds:
  - typedef enum logic [1:0] cmp_state_e {CMP_IDLE, CMP_RUN, CMP_DONE};
  - typedef struct packed {eq, agt, blt} cmp_res_t;
  - helper function bias_sign(x, en), which inverts the MSB when en = 1.
- One sub-module: compare_chunk_u.
  - Combinational, parametrised CHUNK-wide unsigned compare with outputs equal_o / alarger_o / blarger_o.
  - Instantiated once on the muxed slice.
- The FSM, index counter and result registers live in compare_iter_s.

Test Plan:
All scenarios use WIDTH=32, CHUNK=8.
1. Early exit, signed: signed_i=1, a=0xFFFFFFFF, b=0x00000001 -> blarger_o=1, valid_o at E+1. Same operands with signed_i=0 -> alarger_o=1 at E+1.
2. Full scan: a=b=0x12345678, either mode -> equal_o=1 only at E+4. a=0x12345679, b=0x12345678, unsigned -> alarger_o=1 at E+4.
3. Mid exit: a=0x12340000, b=0x12350000 -> blarger_o=1 at E+2. Signed a=0x80000000, b=0x7FFFFFFF -> blarger_o=1 at E+1.
4. Backpressure: hold ready_i=0 for 5 cycles in DONE while toggling valid_i and the operands -> valid_o and results unchanged, ready_o=0, no accept. Pulse ready_i -> next cycle valid_o=0, ready_o=1.
5. Reset mid-RUN: accept a=b=0, then assert rst_i on the second RUN cycle -> next cycle ready_o=1, valid_o=0, all results 0. The transaction never produces an output.
6. Back-to-back random: 1000 random operand pairs with random signed_i and random ready_i stalls -> results match a signed/unsigned reference model. Latency equals the index of the first differing chunk from the MSB plus 1, or 4 when equal. The one-hot invariant is checked every cycle.
